// File: rtl/seg7_scan_driver.sv
// Binary-to-7-segment driver: sequential shift-add-3 BCD conversion, atomic commit
// to display registers, and a free-running multiplexed digit scan.
module seg7_scan_driver #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_value,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              blank_lz,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_en
);

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = 64'(pow10(DIGITS) - 1);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [BW-1:0]    bcdAdj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovfPend_q, ovfPend_d;
    logic [BW-1:0]    disp_q, disp_d;
    logic             overflow_q, overflow_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [IW-1:0]    digIdx_q, digIdx_d;

    logic [DIGITS-1:0] blankVec;
    logic              allZero;
    logic [3:0]        curNib;
    logic              curBlank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovfPend_q  <= 1'b0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
            presc_q    <= '0;
            digIdx_q   <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovfPend_q  <= ovfPend_d;
            disp_q     <= disp_d;
            overflow_q <= overflow_d;
            presc_q    <= presc_d;
            digIdx_q   <= digIdx_d;
        end
    end

    // Display registers are only written in COMMIT so partial results never show.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovfPend_d  = ovfPend_q;
        disp_d     = disp_q;
        overflow_d = overflow_q;
        bcdAdj     = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d     = in_value;
                    bcd_d     = '0;
                    cnt_d     = CW'(WIDTH);
                    ovfPend_d = (64'(in_value) > MAX_VAL);
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = COMMIT;
            end
            COMMIT: begin
                disp_d     = bcd_q;
                overflow_d = ovfPend_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d  = presc_q + PW'(1);
        digIdx_d = digIdx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d  = '0;
            digIdx_d = (digIdx_q == IW'(DIGITS - 1)) ? '0 : digIdx_q + IW'(1);
        end
    end

    // A non-units digit is blankable when it and every digit above it are zero.
    always_comb begin
        allZero  = 1'b1;
        blankVec = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            allZero     = allZero & (disp_q[4*i +: 4] == 4'd0);
            blankVec[i] = allZero;
        end
        curNib   = 4'd0;
        curBlank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digIdx_q == IW'(i)) begin
                curNib   = disp_q[4*i +: 4];
                curBlank = blankVec[i];
            end
        end
        case (curNib)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        if (overflow_q)                seg = 7'b1111110;
        else if (blank_lz && curBlank) seg = 7'b1111111;
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;
    assign dig_en   = DIGITS'(1) << digIdx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: captures are queued with their expected
// commit cycle, and a free-running monitor checks scan, overflow and segments.
module tb_seg7_scan_driver;

    localparam int W    = 10;
    localparam int D    = 3;
    localparam int SD   = 3;
    localparam int MAXV = 999;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_value = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         blank_lz = 1'b0;
    logic         busy;
    logic         overflow;
    logic [6:0]   seg;
    logic [D-1:0] dig_en;

    typedef struct {
        int val;
        int commitCyc;
    } entry_t;

    int     errorCount = 0;
    int     checkCount = 0;
    int     cyc = 0;
    int     modelVal = 0;
    bit     modelOvf = 1'b0;
    bit     prevBusy = 1'b0;
    bit     streaming = 1'b0;
    int     lastPushCyc = -1;
    entry_t sbQueue[$];

    always #5 clk = ~clk;

    seg7_scan_driver #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .blank_lz (blank_lz),
        .busy     (busy),
        .overflow (overflow),
        .seg      (seg),
        .dig_en   (dig_en)
    );

    task automatic checkOutput(input string tag, input int got, input int exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] segModel(input int value, input bit ovf, input bit blank, input int idx);
        int p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (ovf) return 7'b1111110;
        if (blank && idx > 0 && value < p) return 7'b1111111;
        case ((value / p) % 10)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Pops on each commit, then checks the scanned output against the model, then
    // queues any handshake that the next rising edge will accept.
    always @(negedge clk) begin : monitor
        entry_t e;
        int     expIdx;
        if (rst) begin
            sbQueue.delete();
            modelVal    = 0;
            modelOvf    = 1'b0;
            prevBusy    = 1'b0;
            lastPushCyc = -1;
        end else begin
            if (prevBusy && !busy) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("spuriousCommit", 1, 0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("commitCycle", cyc, e.commitCyc);
                    modelVal = e.val;
                    modelOvf = (e.val > MAXV);
                end
            end
            prevBusy = busy;
            expIdx = (cyc / SD) % D;
            checkOutput("digEn", int'(dig_en), 1 << expIdx);
            checkOutput("overflow", int'(overflow), int'(modelOvf));
            checkOutput("seg", int'(seg), int'(segModel(modelVal, modelOvf, blank_lz, expIdx)));
            if (in_valid && in_ready) begin
                if (streaming && lastPushCyc >= 0) checkOutput("captureGap", cyc - lastPushCyc, W + 2);
                lastPushCyc = streaming ? cyc : -1;
                sbQueue.push_back('{val: int'(in_value), commitCyc: cyc + W + 2});
            end
        end
    end

    task automatic applyStimulus(input int value);
        int n = 0;
        @(posedge clk); #1;
        in_value = W'(value);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) checkOutput("readyTimeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) checkOutput("idleTimeout", 0, 1);
    endtask

    task automatic checkDigit(input int idx, input logic [6:0] exp, input string tag);
        int n = 0;
        @(negedge clk);
        while (dig_en !== D'(1 << idx) && n < 2 * D * SD) begin
            n++;
            @(negedge clk);
        end
        checkOutput({tag, "Sel"}, int'(dig_en), 1 << idx);
        checkOutput(tag, int'(seg), int'(exp));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Ready"}, int'(in_ready), 1);
        checkOutput({tag, "Busy"}, int'(busy), 0);
        checkOutput({tag, "Ovf"}, int'(overflow), 0);
        checkOutput({tag, "DigEn"}, int'(dig_en), 1);
        checkOutput({tag, "Seg"}, int'(seg), int'(7'b0000001));
    endtask

    initial begin
        int lowCnt;
        int n;

        repeat (2) @(negedge clk);
        checkResetState("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(255);
        lowCnt = 0;
        @(negedge clk);
        while (!in_ready && lowCnt < 40) begin
            lowCnt++;
            @(negedge clk);
        end
        checkOutput("readyLowCycles", lowCnt, W + 1);
        checkDigit(0, 7'b0100100, "d0v255");
        checkDigit(1, 7'b0100100, "d1v255");
        checkDigit(2, 7'b0010010, "d2v255");

        applyStimulus(1000);
        waitIdle();
        checkOutput("ovfSet", int'(overflow), 1);
        checkDigit(0, 7'b1111110, "d0v1000");
        checkDigit(1, 7'b1111110, "d1v1000");
        checkDigit(2, 7'b1111110, "d2v1000");

        applyStimulus(999);
        waitIdle();
        checkOutput("ovfClear", int'(overflow), 0);
        checkDigit(0, 7'b0000100, "d0v999");
        checkDigit(1, 7'b0000100, "d1v999");
        checkDigit(2, 7'b0000100, "d2v999");

        @(posedge clk); #1;
        blank_lz = 1'b1;
        applyStimulus(7);
        waitIdle();
        checkDigit(2, 7'b1111111, "d2v7blank");
        checkDigit(1, 7'b1111111, "d1v7blank");
        checkDigit(0, 7'b0001111, "d0v7blank");
        @(posedge clk); #1;
        blank_lz = 1'b0;
        checkDigit(2, 7'b0000001, "d2v7show");
        checkDigit(1, 7'b0000001, "d1v7show");

        @(posedge clk); #1;
        blank_lz = 1'b1;
        applyStimulus(0);
        waitIdle();
        checkDigit(0, 7'b0000001, "d0v0blank");
        checkDigit(1, 7'b1111111, "d1v0blank");

        @(posedge clk); #1;
        blank_lz = 1'b0;
        applyStimulus(123);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkResetState("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2 * (W + 2)) @(posedge clk);
        checkDigit(2, 7'b0000001, "d2abort");

        @(posedge clk); #1;
        streaming = 1'b1;
        in_valid  = 1'b1;
        in_value  = W'(960);
        repeat (60) begin
            @(posedge clk); #1;
            in_value = in_value + W'(1);
        end
        in_valid  = 1'b0;
        streaming = 1'b0;

        n = 0;
        @(negedge clk);
        while ((!in_ready || sbQueue.size() != 0) && n < 40) begin
            n++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checkOutput("queueEmpty", sbQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
